// File: rtl/vga_bus_writer_pkg.sv
// Shared constants for the mini-VGA CPU write path: register select codes,
// control bit positions, framebuffer geometry defaults and sequencer states.
// No logic; imported by vga_bus_writer and its bench.
package vga_bus_writer_pkg;

   // Default VRAM geometry
   localparam int VRAM_ADDR_W  = 13;
   localparam int FB_WORDS_DEF = 8000;

   // Z80 register select codes (chipsel)
   localparam logic [1:0] CS_ADDR_LO = 2'd0;
   localparam logic [1:0] CS_ADDR_HI = 2'd1;
   localparam logic [1:0] CS_DATA    = 2'd2;
   localparam logic [1:0] CS_CTRL    = 2'd3;

   // Control register bit positions
   localparam int CTRL_CLEAR   = 0;
   localparam int CTRL_OVF_CLR = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } wr_state_t;

endpackage

// File: rtl/vga_write_fifo.sv
// Purpose: small synchronous FIFO buffering {addr, data} VRAM writes.
// Latency: pushed entry visible on dout the cycle after push; dout is a combinational read of the head.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush empties it and wins over push/pop.
// Ports: clk/rst_n; push/din write side; pop/dout read side; flush; empty/full/count status.
module vga_write_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop) && !flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/vga_bus_writer.sv
// Purpose: Z80 I/O write decoder feeding VRAM through a blanking-gated write FIFO, plus a clear-screen sequencer.
// Latency: command acts 3 clk after write/iorq both go low; a FIFO entry reaches vram_* 1 clk after its pop.
// Backpressure: none to the CPU; data writes to a full FIFO are dropped and flagged on sticky overflow.
// Ports: clk/rst_n; write/iorq (active-low, async) chipsel/data from the CPU; visible from signalgen;
//        vram_we/vram_addr/vram_wdata to VRAM; busy and overflow status.
module vga_bus_writer
   import vga_bus_writer_pkg::*;
#(
   parameter int ADDR_W     = VRAM_ADDR_W,
   parameter int FB_WORDS   = FB_WORDS_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic              iorq,
   input  logic [1:0]        chipsel,
   input  logic [7:0]        data,
   input  logic              visible,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   output logic              busy,
   output logic              overflow
);

   localparam int EW = ADDR_W + 8;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   // Two-flop synchronisers; bus strobes idle high
   logic       write_s1, write_s2, iorq_s1, iorq_s2;
   logic [1:0] cs_s1, cs_s2;
   logic [7:0] data_s1, data_s2;
   logic       bus_act_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_s1  <= 1'b1;
         write_s2  <= 1'b1;
         iorq_s1   <= 1'b1;
         iorq_s2   <= 1'b1;
         cs_s1     <= '0;
         cs_s2     <= '0;
         data_s1   <= '0;
         data_s2   <= '0;
         bus_act_q <= 1'b0;
      end else begin
         write_s1  <= write;
         write_s2  <= write_s1;
         iorq_s1   <= iorq;
         iorq_s2   <= iorq_s1;
         cs_s1     <= chipsel;
         cs_s2     <= cs_s1;
         data_s1   <= data;
         data_s2   <= data_s1;
         bus_act_q <= !write_s2 && !iorq_s2;
      end
   end

   // Rising edge of the synced "bus cycle active" condition: one per CPU write.
   logic strobe;
   assign strobe = !write_s2 && !iorq_s2 && !bus_act_q;

   wr_state_t         state;
   logic [ADDR_W-1:0] addr_ptr;
   logic [ADDR_W-1:0] clear_ptr;

   logic          is_data, clear_cmd, ovf_clr, pop, drop;
   logic          fifo_empty, fifo_full;
   logic [EW-1:0] fifo_dout;
   logic [CW-1:0] fifo_count;

   assign is_data   = strobe && (cs_s2 == CS_DATA);
   assign clear_cmd = strobe && (cs_s2 == CS_CTRL) && data_s2[CTRL_CLEAR];
   assign ovf_clr   = strobe && (cs_s2 == CS_CTRL) && data_s2[CTRL_OVF_CLR];
   // A clear command flushes the FIFO, so nothing may be popped that cycle.
   assign pop       = (state == ST_IDLE) && !visible && !fifo_empty && !clear_cmd;
   assign drop      = is_data && fifo_full && !pop;
   assign busy      = (state == ST_CLEAR) || (fifo_count != '0);

   vga_write_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (is_data),
      .pop   (pop),
      .flush (clear_cmd),
      .din   ({addr_ptr, data_s2}),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr_ptr   <= '0;
         clear_ptr  <= '0;
         vram_we    <= 1'b0;
         vram_addr  <= '0;
         vram_wdata <= '0;
         overflow   <= 1'b0;
      end else begin
         vram_we <= 1'b0;

         if (strobe) begin
            case (cs_s2)
               CS_ADDR_LO: addr_ptr[7:0]        <= data_s2;
               CS_ADDR_HI: addr_ptr[ADDR_W-1:8] <= data_s2[ADDR_W-9:0];
               CS_DATA:    addr_ptr             <= ptr_inc(addr_ptr);
               CS_CTRL:    ;
            endcase
         end

         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;

         if (clear_cmd) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (pop) begin
                     vram_we    <= 1'b1;
                     vram_addr  <= fifo_dout[EW-1:8];
                     vram_wdata <= fifo_dout[7:0];
                  end
               end
               ST_CLEAR: begin
                  if (!visible) begin
                     vram_we    <= 1'b1;
                     vram_addr  <= clear_ptr;
                     vram_wdata <= '0;
                     if (clear_ptr == LAST_ADDR) state <= ST_IDLE;
                     else clear_ptr <= clear_ptr + 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_bus_writer.sv
// Bench for vga_bus_writer: directed register table, blanking/overflow/wrap/clear
// sequences, reset mid-clear, and randomized bursts against a queue-based model.
module tb_vga_bus_writer;
   import vga_bus_writer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write = 1'b1;
   logic        iorq = 1'b1;
   logic [1:0]  chipsel = 2'd0;
   logic [7:0]  data = 8'd0;
   logic        visible = 1'b1;
   logic        vram_we;
   logic [12:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        busy;
   logic        overflow;

   vga_bus_writer #(.ADDR_W(13), .FB_WORDS(8000), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .iorq       (iorq),
      .chipsel    (chipsel),
      .data       (data),
      .visible    (visible),
      .vram_we    (vram_we),
      .vram_addr  (vram_addr),
      .vram_wdata (vram_wdata),
      .busy       (busy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every VRAM write, with the cycle it appeared in
   typedef struct {
      logic [12:0] a;
      logic [7:0]  d;
      int          cyc;
   } wr_t;

   wr_t  got[$];
   int   cyc = 0;
   logic vis_q = 1'b1;
   int   viol = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      vis_q <= visible;
   end

   always @(negedge clk) begin
      if (vram_we === 1'b1) begin
         if (vis_q) viol++;
         got.push_back('{vram_addr, vram_wdata, cyc});
      end
   end

   // Reference model: pointer, pending writes (what the buffer should hold), sticky flag
   logic [12:0] m_ptr = 13'd0;
   logic        m_ovf = 1'b0;
   logic [20:0] pend_q[$];

   function automatic void m_apply(input logic [1:0] cs, input logic [7:0] d);
      case (cs)
         2'd0: m_ptr = {m_ptr[12:8], d};
         2'd1: m_ptr = {d[4:0], m_ptr[7:0]};
         2'd2: begin
            if (pend_q.size() < 4) pend_q.push_back({m_ptr, d});
            else m_ovf = 1'b1;
            m_ptr = (m_ptr == 13'd7999) ? 13'd0 : m_ptr + 13'd1;
         end
         default: begin
            if (d[1]) m_ovf = 1'b0;
            if (d[0]) pend_q.delete();
         end
      endcase
   endfunction

   task automatic bus_wr(input logic [1:0] cs, input logic [7:0] d);
      @(posedge clk); #2;
      chipsel = cs;
      data    = d;
      write   = 1'b0;
      iorq    = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      write = 1'b1;
      iorq  = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic op(input logic [1:0] cs, input logic [7:0] d);
      bus_wr(cs, d);
      m_apply(cs, d);
   endtask

   task automatic set_vis(input logic v);
      @(posedge clk); #2;
      visible = v;
   endtask

   // Compare writes captured since index n0 with the model's pending list, then retire it
   task automatic check_drain(input string name, input int n0);
      chk({name, "_cnt"}, got.size() - n0, pend_q.size());
      for (int i = 0; i < pend_q.size(); i++) begin
         if (n0 + i < got.size())
            chk({name, "_wr"}, {got[n0+i].a, got[n0+i].d}, pend_q[i]);
      end
      pend_q.delete();
   endtask

   typedef struct {
      logic [1:0]  cs;
      logic [7:0]  d;
      int          n;
      logic [12:0] a;
      logic [7:0]  wd;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0, n1, bad, k;
      logic [1:0] cs;
      logic [7:0] d;

      tbl[0]  = '{2'd0, 8'h34, 0, 13'h0000, 8'h00};
      tbl[1]  = '{2'd1, 8'h12, 0, 13'h0000, 8'h00};
      tbl[2]  = '{2'd2, 8'hAB, 1, 13'h1234, 8'hAB};
      tbl[3]  = '{2'd2, 8'hCD, 1, 13'h1235, 8'hCD};
      tbl[4]  = '{2'd0, 8'h3F, 0, 13'h0000, 8'h00};
      tbl[5]  = '{2'd1, 8'h1F, 0, 13'h0000, 8'h00};
      tbl[6]  = '{2'd2, 8'h01, 1, 13'h1F3F, 8'h01};
      tbl[7]  = '{2'd2, 8'h02, 1, 13'h0000, 8'h02};
      tbl[8]  = '{2'd1, 8'hFF, 0, 13'h0000, 8'h00};
      tbl[9]  = '{2'd0, 8'h80, 0, 13'h0000, 8'h00};
      tbl[10] = '{2'd2, 8'h77, 1, 13'h1F80, 8'h77};

      // Reset state
      #1;
      chk("rst_we", vram_we, 0);
      chk("rst_addr", vram_addr, 0);
      chk("rst_wdata", vram_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed register table, visible low so each data byte drains at once
      set_vis(1'b0);
      for (int i = 0; i < 11; i++) begin
         n0 = got.size();
         op(tbl[i].cs, tbl[i].d);
         repeat (2) @(posedge clk);
         chk($sformatf("tbl%0d_cnt", i), got.size() - n0, tbl[i].n);
         if (tbl[i].n == 1 && got.size() > n0) begin
            chk($sformatf("tbl%0d_addr", i), got[$].a, tbl[i].a);
            chk($sformatf("tbl%0d_data", i), got[$].d, tbl[i].wd);
         end
         chk($sformatf("tbl%0d_busy", i), busy, 0);
         pend_q.delete();
      end

      // Blanking gate: buffered while visible, drained back-to-back afterwards
      set_vis(1'b1);
      n0 = got.size();
      op(CS_DATA, 8'h11);
      op(CS_DATA, 8'h22);
      op(CS_DATA, 8'h33);
      chk("blank_busy", busy, 1);
      chk("blank_no_we", got.size() - n0, 0);
      set_vis(1'b0);
      repeat (8) @(posedge clk);
      if (got.size() >= n0 + 3) begin
         chk("blank_consec1", got[n0+1].cyc - got[n0].cyc, 1);
         chk("blank_consec2", got[n0+2].cyc - got[n0+1].cyc, 1);
      end
      check_drain("blank", n0);
      chk("blank_busy_done", busy, 0);

      // Overflow: fifth write while visible is dropped
      set_vis(1'b1);
      n0 = got.size();
      for (int i = 0; i < 5; i++) op(CS_DATA, 8'hA0 + 8'(i));
      chk("ovf_set", overflow, 1);
      set_vis(1'b0);
      repeat (10) @(posedge clk);
      check_drain("ovf", n0);
      chk("ovf_sticky", overflow, 1);
      op(CS_CTRL, 8'h02);
      chk("ovf_clr", overflow, 0);

      // Clear: pre-clear byte discarded, 8000 zeros, then the post-command byte
      set_vis(1'b1);
      op(CS_ADDR_LO, 8'h00);
      op(CS_ADDR_HI, 8'h01);
      op(CS_DATA, 8'hEE);
      op(CS_CTRL, 8'h01);
      chk("clr_busy", busy, 1);
      op(CS_DATA, 8'h55);
      n0 = got.size();
      set_vis(1'b0);
      k = 0;
      while (busy && k < 9000) begin
         @(negedge clk);
         k++;
      end
      chk("clr_done", busy, 0);
      repeat (3) @(negedge clk);
      chk("clr_total", got.size() - n0, 8001);
      bad = 0;
      for (int i = 0; i < 8000; i++) begin
         if (n0 + i >= got.size()) bad++;
         else if (got[n0+i].a != 13'(i) || got[n0+i].d != 8'h00) bad++;
      end
      chk("clr_zero_writes", bad, 0);
      check_drain("clr_post", n0 + 8000);

      // Reset in the middle of a clear
      n0 = got.size();
      op(CS_CTRL, 8'h01);
      k = 0;
      while (got.size() - n0 < 100 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("rstclr_reached", (got.size() - n0 >= 100) ? 1 : 0, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstclr_we", vram_we, 0);
      chk("rstclr_busy", busy, 0);
      n1 = got.size();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      m_ptr = 13'd0;
      m_ovf = 1'b0;
      pend_q.delete();
      repeat (50) @(posedge clk);
      chk("rstclr_quiet", got.size() - n1, 0);

      // Randomized bursts: buffer while visible, then drain fully
      for (int b = 0; b < 20; b++) begin
         set_vis(1'b1);
         n0 = got.size();
         k = $urandom_range(1, 7);
         for (int j = 0; j < k; j++) begin
            case ($urandom_range(0, 7))
               0: cs = CS_ADDR_LO;
               1: cs = CS_ADDR_HI;
               2: cs = CS_CTRL;
               default: cs = CS_DATA;
            endcase
            d = 8'($urandom);
            if (cs == CS_CTRL) d[0] = 1'b0;
            op(cs, d);
         end
         chk($sformatf("rnd%0d_ovf", b), overflow, m_ovf);
         chk($sformatf("rnd%0d_busy", b), busy, (pend_q.size() != 0) ? 1 : 0);
         chk($sformatf("rnd%0d_held", b), got.size() - n0, 0);
         set_vis(1'b0);
         repeat (10) @(posedge clk);
         check_drain($sformatf("rnd%0d", b), n0);
         chk($sformatf("rnd%0d_idle", b), busy, 0);
      end

      chk("no_we_while_visible", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_bus_writer.md
Name: vga_bus_writer

Overview:
- CPU-side front end of the mini-VGA peripheral, directly upstream of the pixel generator's video RAM.
- Decodes Z80 I/O writes (write, iorq, chipsel, data), maintains an auto-incrementing VRAM address pointer, and buffers byte writes in a small FIFO.
- Drains the FIFO into the single-port VRAM only while the raster is outside the visible area, so pixel fetches are never disturbed.
- Provides a hardware clear-screen sequencer.

Parameters:
- ADDR_W, 13: VRAM address width.
- FB_WORDS, 8000: number of framebuffer bytes; the clear range and the address wrap point.
- FIFO_DEPTH, 4: write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- write  in  1  Z80 write strobe, active-low, asynchronous to clk.
- iorq  in  1  Z80 I/O request, active-low, asynchronous to clk.
- chipsel  in  2  register select.
- data  in  8  CPU data bus.
- visible  in  1  from signalgen; 1 = active video, VRAM owned by pixelgen.
- vram_we  out  1  one-cycle VRAM write enable.
- vram_addr  out  ADDR_W  VRAM write address.
- vram_wdata  out  8  VRAM write data.
- busy  out  1  clear in progress or FIFO non-empty.
- overflow  out  1  sticky: a data write was dropped.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Synchroniser flops = 1 (bus inactive); captured chipsel/data = 0.
  - addr_ptr = 0; FIFO empty; state IDLE; clear_ptr = 0.
  - vram_we = 0, vram_addr = 0, vram_wdata = 0; overflow = 0.
- Input synchronisation:
  - write, iorq, chipsel and data each pass through a 2-flop synchroniser.
  - strobe = one-cycle pulse on the first cycle where synced (write==0 && iorq==0) follows a cycle where it was not. Exactly one strobe per bus cycle.
  - Command action occurs 3 clk after both inputs go low.
- Register decode on strobe (synced chipsel):
  - 0: addr_ptr[7:0] = data.
  - 1: addr_ptr[ADDR_W-1:8] = data[ADDR_W-9:0]; upper data bits ignored.
  - 2: push {addr_ptr, data} into the FIFO, then increment addr_ptr. FB_WORDS-1 wraps to 0.
  - 3: control. data[0]=1 starts a clear; data[1]=1 clears overflow. Both bits set does both.
- FIFO push:
  - Accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set; addr_ptr still increments.
- States:
  - IDLE: when visible==0 and the FIFO is non-empty, pop one entry per cycle. Next cycle: vram_we=1, vram_addr/vram_wdata = entry (registered outputs, 1-cycle latency).
  - CLEAR: entered from IDLE or CLEAR on a clear command.
    - On entry the FIFO is flushed (pre-clear writes are discarded) and clear_ptr = 0.
    - Each cycle with visible==0: vram_we=1, addr=clear_ptr, wdata=0, then clear_ptr increments.
    - After the write of FB_WORDS-1, return to IDLE.
    - No FIFO pops occur during CLEAR. Pushes still occur and drain after the clear.
    - A clear command during CLEAR restarts from 0.
- visible==1: vram_we is 0 on the following cycle, no exceptions. Any operation in progress pauses and resumes when visible returns to 0.
- vram_we is 0 whenever there is no write. vram_addr/vram_wdata hold their last values.
- busy = (state==CLEAR) || (FIFO count != 0). Combinational from registers.
- Reset mid-clear or with a non-empty FIFO: all pending writes are abandoned.

Decomposition:
- vgaspecs.vh gains:
  - chipsel codes (CS_ADDR_LO=0, CS_ADDR_HI=1, CS_DATA=2, CS_CTRL=3);
  - control bit indices (CTRL_CLEAR=0, CTRL_OVF_CLR=1);
  - FB_WORDS and VRAM_ADDR_W defaults.
- Sub-module vga_write_fifo: synchronous FIFO, width ADDR_W+8, depth FIFO_DEPTH.
  - Ports: push, pop, flush, din, dout, empty, full, count.
  - Same clk/rst_n.

Test Plan:
- Address and data write: bus writes CS0=0x34, CS1=0x12, CS2=0xAB with visible=0 -> single vram_we pulse, addr=0x1234, wdata=0xAB; addr_ptr then reads 0x1235 (observed on the next CS2 write).
- Blanking gate: with visible=1, write CS2 0x11, 0x22, 0x33 -> no vram_we while visible=1 and busy=1. Drop visible -> three consecutive writes, 0x11, 0x22, 0x33, at addr n..n+2; then busy=0.
- Overflow: with visible=1, issue 5 CS2 writes at FIFO_DEPTH=4 -> overflow=1 and only the first 4 are written after blanking. CS3 data=0x02 -> overflow=0.
- Wrap: set addr 7999 (0x1F3F), write two bytes -> VRAM writes at 7999 then 0.
- Clear: CS2 write with visible=1, then CS3 0x01, then CS2 0x55 -> the pre-clear byte is never written. Exactly 8000 zero writes covering 0..7999, then 0x55 at the expected address; busy stays high until done.
- Async reset mid-clear: assert rst_n=0 at clear_ptr=100 -> vram_we=0 immediately, busy=0; after release, no further writes.
